// File: rtl/ila_trigger_ctrl.sv
// ila_trigger_ctrl
// ----------------
// Capture controller for an integrated logic analyser. It combines the
// per-channel trigger-logic outputs into one trigger (OR or AND reduction),
// generates write enable and address for a circular sample buffer and
// tracks where the trigger sample landed.
//
// Optional feature macro: IOB_ILA_POST_TRIGGER_EN
//   defined   : after the trigger, post_count further samples are written
//               (POST state, down-counter of CNT_W bits).
//   undefined : the trigger sample is the last sample written; post_count
//               is ignored and no counter exists.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   arm           start or restart a capture (IDLE/DONE only)
//   disarm        abort to IDLE from any state (beats arm and trigger)
//   trigger_vec   per-channel trigger-logic outputs (NTRIG bits)
//   reduce_type   IOB_ILA_REDUCE_OR (1'b1) selects OR, otherwise AND
//   sample_en     sample qualifier; a buffer write happens only when high
//   post_count    samples to write after the trigger sample
//   capture_we    buffer write enable (combinational)
//   capture_addr  buffer write address
//   trig_addr     buffer address of the trigger sample
//   triggered     trigger seen since last arm
//   wrapped       write address wrapped since last arm
//   done          capture complete
//   state         FSM state code: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
module ila_trigger_ctrl #(
    parameter int NTRIG  = 4,
    parameter int BUF_AW = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              disarm,
    input  logic [NTRIG-1:0]  trigger_vec,
    input  logic              reduce_type,
    input  logic              sample_en,
    input  logic [CNT_W-1:0]  post_count,
    output logic              capture_we,
    output logic [BUF_AW-1:0] capture_addr,
    output logic [BUF_AW-1:0] trig_addr,
    output logic              triggered,
    output logic              wrapped,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic IOB_ILA_REDUCE_OR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_AW-1:0] addr_q, addr_d;
    logic [BUF_AW-1:0] taddr_q, taddr_d;
    logic              triggered_q, triggered_d;
    logic              wrapped_q, wrapped_d;
    logic              trig_s;
    logic              we_s;
    logic              clear_s;

`ifdef IOB_ILA_POST_TRIGGER_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    logic [CNT_W-1:0]  unused_post_count_s;
    assign unused_post_count_s = post_count;
`endif

    // Reduce the channel trigger vector to a single trigger
    always_comb begin
        trig_s = 1'b0;
        if (reduce_type == IOB_ILA_REDUCE_OR) begin
            trig_s = |trigger_vec;
        end else begin
            trig_s = &trigger_vec;
        end
    end

    // Buffer write enable: qualified sample while capturing
    always_comb begin
        we_s = 1'b0;
        case (state_q)
            ST_ARMED: we_s = sample_en;
            ST_POST:  we_s = sample_en;
            default:  we_s = 1'b0;
        endcase
    end

    // FSM next state, trigger bookkeeping and post-trigger counter
    always_comb begin
        state_d     = state_q;
        taddr_d     = taddr_q;
        triggered_d = triggered_q;
        clear_s     = 1'b0;
`ifdef IOB_ILA_POST_TRIGGER_EN
        cnt_d       = cnt_q;
`endif
        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d     = ST_ARMED;
                        triggered_d = 1'b0;
                        clear_s     = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ARMED: begin
                    if (trig_s) begin
                        // The trigger sample goes to the current address
                        taddr_d     = addr_q;
                        triggered_d = 1'b1;
`ifdef IOB_ILA_POST_TRIGGER_EN
                        cnt_d = post_count;
                        if (post_count == {CNT_W{1'b0}}) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
`ifdef IOB_ILA_POST_TRIGGER_EN
                    // Only real writes consume the post-trigger budget
                    if (we_s) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_POST;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Write address and wrap flag
    always_comb begin
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (clear_s) begin
            addr_d    = {BUF_AW{1'b0}};
            wrapped_d = 1'b0;
        end else if (we_s) begin
            addr_d = addr_q + BUF_AW'(1);
            if (addr_q == {BUF_AW{1'b1}}) begin
                wrapped_d = 1'b1;
            end else begin
                wrapped_d = wrapped_q;
            end
        end else begin
            addr_d    = addr_q;
            wrapped_d = wrapped_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {BUF_AW{1'b0}};
            taddr_q     <= {BUF_AW{1'b0}};
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
`ifdef IOB_ILA_POST_TRIGGER_EN
            cnt_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            taddr_q     <= taddr_d;
            triggered_q <= triggered_d;
            wrapped_q   <= wrapped_d;
`ifdef IOB_ILA_POST_TRIGGER_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign capture_we   = we_s;
    assign capture_addr = addr_q;
    assign trig_addr    = taddr_q;
    assign triggered    = triggered_q;
    assign wrapped      = wrapped_q;
    assign done         = (state_q == ST_DONE);
    assign state        = state_q;

endmodule

// File: doc/ila_trigger_ctrl.md
ILA_TRIGGER_CTRL -- requirements
Module: ila_trigger_ctrl

Interface
REQ-001 SHALL have parameter NTRIG, default 4: number of trigger-logic outputs combined (>=1).
REQ-002 SHALL have parameter BUF_AW, default 10: sample-buffer address width.
REQ-003 SHALL have parameter CNT_W, default 16: post-trigger counter width.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arm  in  1  start or restart capture.
- disarm  in  1  abort to IDLE.
- trigger_vec  in  NTRIG  per-channel trigger-logic outputs.
- reduce_type  in  1  IOB_ILA_REDUCE_OR selects OR; any other value selects AND.
- sample_en  in  1  sample qualifier; a buffer write occurs only when high.
- post_count  in  CNT_W  samples to write after the trigger sample.
- capture_we  out  1  buffer write enable.
- capture_addr  out  BUF_AW  buffer write address.
- trig_addr  out  BUF_AW  address of the trigger sample.
- triggered  out  1  trigger seen since last arm.
- wrapped  out  1  address wrapped since last arm.
- done  out  1  capture complete.
- state  out  2  FSM state code.

Function
REQ-006 trig SHALL be combinational: |trigger_vec for OR, &trigger_vec for AND.
REQ-007 FSM SHALL have states IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-008 capture_we SHALL equal sample_en in ARMED and POST, and 0 in IDLE and DONE (combinational).
REQ-009 capture_addr SHALL increment by 1 after each cycle with capture_we=1, wrapping from 2^BUF_AW-1 to 0; on wrap, wrapped SHALL be set.
REQ-010 IDLE: arm=1 -> ARMED next cycle, with capture_addr, wrapped and triggered cleared.
REQ-011 ARMED: trig=1 -> POST next cycle; trig_addr SHALL latch the current capture_addr; triggered SHALL be set; counter SHALL load post_count; the trigger-cycle sample SHALL be written if sample_en=1.
REQ-012 ARMED with trig=1 and post_count=0 SHALL go directly to DONE.
REQ-013 POST: each write SHALL decrement the counter; the write with counter==1 SHALL move the FSM to DONE next cycle. trig is ignored in POST.
REQ-014 DONE: done=1, capture_addr held; arm=1 -> ARMED with the clears of REQ-010.
REQ-015 disarm=1 SHALL force IDLE next cycle from any state; disarm has priority over arm and trig.
REQ-016 trig SHALL be ignored outside ARMED, including the cycle in which arm is sampled in IDLE.
REQ-017 arm in ARMED or POST SHALL be ignored.
REQ-018 Latency: trig in cycle N (ARMED) -> triggered=1 and state=POST in cycle N+1.

Reset
REQ-019 On rst: state=IDLE, capture_addr=0, trig_addr=0, counter=0, triggered=0, wrapped=0, done=0. capture_we=0 follows from IDLE.
REQ-020 rst mid-capture SHALL abort with no further writes from the next cycle; rst has priority over disarm and arm.

Configuration
REQ-021 Macro IOB_ILA_POST_TRIGGER_EN: when defined, POST state and counter as above.
REQ-022 When IOB_ILA_POST_TRIGGER_EN is undefined:
- post_count is ignored.
- No counter is instantiated.
- ARMED with trig=1 SHALL go to DONE next cycle; the trigger sample is the last sample written.
- State code 2 is never produced.

Verification
REQ-023 NTRIG=4, OR, trigger_vec=4'b0100 at cycle 5 after arm, sample_en=1, post_count=3 -> trig_addr=5, 3 further writes at addresses 6-8, done=1 after the write at 8, capture_addr=9.
REQ-024 AND mode, trigger_vec=4'b0111 -> no trigger; then 4'b1111 -> triggered=1 one cycle later.
REQ-025 BUF_AW=3, no trigger for 10 samples -> capture_addr wraps 7->0, wrapped=1, capture_addr=2.
REQ-026 arm and disarm asserted together in IDLE -> stays IDLE; disarm in POST -> IDLE next cycle, capture_we=0.
REQ-027 post_count=0 with trigger -> DONE next cycle, exactly one write (the trigger sample); with macro undefined and post_count=5 -> same result.
REQ-028 sample_en toggling 1,0,1,0 in POST with post_count=2 -> counter decrements only on writes; DONE after the 2nd post-trigger write.
